muldiv_unit: RTL

Iterative RV32M multiply/divide unit, parametrised in datapath width. It sits beside the single-cycle integer ALU in the execute stage. It decodes the M-extension instruction itself and runs a one-bit-per-cycle shift-add multiply or restoring divide. Results are returned through a start/busy/done handshake so the core can stall on long-latency ops.

---
 rtl/muldiv_unit.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle shift-add multiply / restoring divide.
// Define MULDIV_DIV_EN to build the divide datapath; otherwise funct3 1xx decodes as illegal.
module muldiv_unit #(
  parameter int INSTRUCTION_LEN = 32,
  parameter int N               = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [INSTRUCTION_LEN-1:0] instruction,
  input  logic [N-1:0]               data_1,
  input  logic [N-1:0]               data_2,
  output logic                       busy,
  output logic                       done,
  output logic [N-1:0]               data_out,
  output logic                       illegal
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [N-1:0]   lo_q, lo_d;
  logic [N-1:0]   opb_q, opb_d;
  logic [N-1:0]   data_out_q, data_out_d;
  logic           mul_lo_q, mul_lo_d;
  logic           neg_q, neg_d;
  logic           bypass_q, bypass_d;
  logic           ill_q, ill_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           illegal_q, illegal_d;
`ifdef MULDIV_DIV_EN
  logic           is_div_q, is_div_d;
  logic           is_rem_q, is_rem_d;
`endif

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_instr;

  assign opcode       = instruction[6:0];
  assign funct3       = instruction[14:12];
  assign funct7       = instruction[31:25];
  assign unused_instr = ^instruction;

  logic         legal, sa_en, sb_en, a_neg, b_neg;
  logic [N-1:0] mag_a, mag_b;

`ifdef MULDIV_DIV_EN
  assign legal = (opcode == 7'd51) && (funct7 == 7'h01);
`else
  assign legal = (opcode == 7'd51) && (funct7 == 7'h01) && !funct3[2];
`endif
  assign sa_en = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign sb_en = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign a_neg = sa_en && data_1[N-1];
  assign b_neg = sb_en && data_2[N-1];
  assign mag_a = a_neg ? -data_1 : data_1;
  assign mag_b = b_neg ? -data_2 : data_2;

  // Multiply step: lo_q holds the multiplier, opb_q the multiplicand, acc_q the running high half.
  logic [N:0] mul_sum;
  assign mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : {(N+1){1'b0}});

  logic [2*N-1:0] prod, prod_fix;
  logic [N-1:0]   mul_res, fin_res;
  assign prod     = {acc_q, lo_q};
  assign prod_fix = neg_q ? -prod : prod;
  assign mul_res  = mul_lo_q ? prod_fix[N-1:0] : prod_fix[2*N-1:N];

`ifdef MULDIV_DIV_EN
  // Divide step: lo_q shifts dividend bits out and quotient bits in, acc_q is the partial remainder.
  logic [N:0]   div_shift, div_diff;
  logic [N-1:0] div_rem, div_quo, div_sel, div_res;
  assign div_shift = {acc_q, lo_q[N-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_rem   = div_diff[N] ? div_shift[N-1:0] : div_diff[N-1:0];
  assign div_quo   = {lo_q[N-2:0], ~div_diff[N]};
  assign div_sel   = is_rem_q ? acc_q : lo_q;
  assign div_res   = neg_q ? -div_sel : div_sel;
  assign fin_res   = bypass_q ? lo_q : (is_div_q ? div_res : mul_res);
`else
  assign fin_res   = bypass_q ? lo_q : mul_res;
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_q;
    lo_d       = lo_q;
    opb_d      = opb_q;
    mul_lo_d   = mul_lo_q;
    neg_d      = neg_q;
    bypass_d   = bypass_q;
    ill_d      = ill_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    data_out_d = data_out_q;
    illegal_d  = illegal_q;
`ifdef MULDIV_DIV_EN
    is_div_d   = is_div_q;
    is_rem_d   = is_rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d   = 1'b1;
          mul_lo_d = (funct3 == 3'b000);
          neg_d    = a_neg ^ b_neg;
          ill_d    = !legal;
          bypass_d = 1'b0;
          acc_d    = '0;
          lo_d     = mag_a;
          opb_d    = mag_b;
          count_d  = CW'(N);
          state_d  = CALC;
`ifdef MULDIV_DIV_EN
          is_div_d = funct3[2];
          is_rem_d = funct3[1];
          // Remainder follows the dividend's sign only.
          if (funct3[2] && funct3[1]) neg_d = a_neg;
`endif
          if (!legal) begin
            bypass_d = 1'b1;
            lo_d     = '0;
            state_d  = FIN;
          end
`ifdef MULDIV_DIV_EN
          else if (funct3[2] && (data_2 == '0)) begin
            bypass_d = 1'b1;
            lo_d     = funct3[1] ? data_1 : '1;
            state_d  = FIN;
          end else if (funct3[2] && !funct3[0] &&
                       (data_1 == {1'b1, {(N-1){1'b0}}}) && (data_2 == '1)) begin
            bypass_d = 1'b1;
            lo_d     = funct3[1] ? '0 : data_1;
            state_d  = FIN;
          end
`endif
        end
      end
      CALC: begin
        count_d = count_q - CW'(1);
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
          acc_d = div_rem;
          lo_d  = div_quo;
        end else
`endif
        begin
          acc_d = mul_sum[N:1];
          lo_d  = {mul_sum[0], lo_q[N-1:1]};
        end
        if (count_q == CW'(1)) state_d = FIN;
      end
      FIN: begin
        done_d     = 1'b1;
        busy_d     = 1'b0;
        data_out_d = fin_res;
        illegal_d  = ill_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      acc_q      <= '0;
      lo_q       <= '0;
      opb_q      <= '0;
      mul_lo_q   <= 1'b0;
      neg_q      <= 1'b0;
      bypass_q   <= 1'b0;
      ill_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= '0;
      illegal_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_q   <= 1'b0;
      is_rem_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      lo_q       <= lo_d;
      opb_q      <= opb_d;
      mul_lo_q   <= mul_lo_d;
      neg_q      <= neg_d;
      bypass_q   <= bypass_d;
      ill_q      <= ill_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
      illegal_q  <= illegal_d;
`ifdef MULDIV_DIV_EN
      is_div_q   <= is_div_d;
      is_rem_q   <= is_rem_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = data_out_q;
  assign illegal  = illegal_q;

endmodule
